serial_parity_checker: RTL and testbench
========================================

// Module: serial_parity_checker
// PURPOSE
//  Serial successor to the 4-bit combinational odd-parity checker. Receives frames of
//  DATA_W data bits plus one parity bit, one bit per accepted cycle, MSB first.
//  Emits the deserialised word with a parity-error flag.
//  Sits between a bit-serial link front end and the word-level consumer.
// PARAMETERS
//  DATA_W  4  data bits per frame (>=1); parity bit follows the last data bit
//  ODD     1  1 = odd parity (ones in data+parity must be odd); 0 = even parity
//  CNT_W   8  width of error counter (used only with PARITY_ERR_CNT_EN)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       in_bit/frame_start qualified this cycle
//  in_bit       in   1       serial data/parity bit
//  frame_start  in   1       with in_valid: in_bit is first (MSB) data bit of a new frame
//  busy         out  1       1 while a frame is in progress (state != IDLE)
//  out_valid    out  1       one-cycle pulse: out_data/pec updated
//  out_data     out  DATA_W  last completed data word, MSB = first received bit
//  pec          out  1       parity error of last completed frame (1 = error)
//  err_cnt      out  CNT_W   saturating count of error frames (only with PARITY_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, bit counter=0, shift reg=0.
//  - Reset values: busy=0, out_valid=0, out_data=0, pec=0, err_cnt=0.
//  - rst has priority over every other input; reset mid-frame discards the partial frame.
//  - A reset mid-frame produces no out_valid.
//  - A bit is accepted only when in_valid=1; with in_valid=0 all state holds (gaps allowed).
//  - FSM:
//    IDLE:   in_valid&frame_start -> load bit as MSB, cnt=1, go DATA (PARITY if DATA_W==1).
//            Valid bits without frame_start are ignored.
//    DATA:   each accepted bit shifts in (running XOR updated), cnt++.
//            When cnt reaches DATA_W -> PARITY.
//    PARITY: accepted bit is parity; go IDLE. At that clock edge:
//            out_data<=word, pec<=~(xor_data^in_bit) if ODD else (xor_data^in_bit).
//            out_valid=1 the following cycle only.
//  - Latency: out_valid is high in the cycle after the edge that samples the parity bit.
//  - out_data and pec hold until the next out_valid; out_valid never asserts for an aborted frame.
//  - in_valid&frame_start in DATA or PARITY: abort current frame (no output).
//    That bit becomes MSB of a new frame (cnt=1).
//  - Back-to-back: frame_start on the cycle after the parity bit is accepted normally.
//  - No throughput loss on back-to-back frames.
//  - Running parity = XOR of accepted data bits; it is cleared on every frame_start.
// CONFIGURATION
//  PARITY_ERR_CNT_EN defined:
//    - err_cnt port present.
//    - err_cnt increments on the same edge pec is loaded with 1.
//    - err_cnt saturates at 2**CNT_W-1; cleared only by rst.
//  Not defined:
//    - err_cnt port and counter logic absent.
//    - All other behaviour identical.
// TESTING  (DATA_W=4, ODD=1 unless noted)
//  1. frame 1,0,1,1 parity 0, in_valid continuous.
//     -> one cycle after parity: out_valid=1, out_data=4'b1011, pec=0.
//  2. frame 0,0,0,0 parity 0 -> out_data=4'b0000, pec=1.
//     Same with ODD=0 -> pec=0.
//  3. frame 1,1,0,0 p=1 with in_valid low 3 cycles between each bit
//     -> single out_valid, out_data=4'b1100, pec=0; busy=1 through gaps.
//  4. frame_start asserted on 3rd bit of a frame, then 4 more bits + parity
//     -> exactly one out_valid; out_data = new frame's bits.
//  5. two frames back-to-back, then rst after 2 bits of a third frame
//     -> two out_valid pulses; after rst all outputs 0, no third out_valid.
//  6. PARITY_ERR_CNT_EN, CNT_W=2: five error frames (0000/p=0)
//     -> err_cnt 1,2,3,3,3; rst -> 0.

Source files
------------

// File: rtl/serial_parity_checker.sv
// ============================================================================
// Module  : serial_parity_checker
// Brief   : MSB-first bit-serial frame receiver (DATA_W data bits + 1 parity
//           bit) producing the deserialised word and a parity-error flag.
//           Optional saturating error counter enabled by PARITY_ERR_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_checker #(
   parameter int DATA_W = 4,
   parameter bit ODD    = 1'b1,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_bit,
   input  logic              frame_start,
   output logic              busy,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              pec
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0]  err_cnt
`endif
);

   localparam int c_CNT_BITS = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [c_CNT_BITS-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]     shift_q, shift_d;
   logic                  xor_q, xor_d;
   logic [DATA_W-1:0]     out_data_q, out_data_d;
   logic                  pec_q, pec_d;
   logic                  out_valid_q, out_valid_d;

   logic [DATA_W:0]       w_shift_cat;
   logic [c_CNT_BITS-1:0] w_cnt_inc;
   logic                  w_par;

   assign w_shift_cat = {shift_q, in_bit};
   assign w_cnt_inc   = cnt_q + c_CNT_BITS'(1);
   assign w_par       = xor_q ^ in_bit;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      xor_d       = xor_q;
      out_data_d  = out_data_q;
      pec_d       = pec_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         // frame_start wins in any state: a partial frame is simply dropped
         if (frame_start) begin
            shift_d = DATA_W'(in_bit);
            xor_d   = in_bit;
            cnt_d   = c_CNT_BITS'(1);
            state_d = (DATA_W == 1) ? ST_PARITY : ST_DATA;
         end else begin
            case (state_q)
               ST_DATA: begin
                  shift_d = w_shift_cat[DATA_W-1:0];
                  xor_d   = w_par;
                  cnt_d   = w_cnt_inc;
                  if (w_cnt_inc == c_CNT_BITS'(DATA_W)) begin
                     state_d = ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  out_data_d  = shift_q;
                  pec_d       = ODD ? ~w_par : w_par;
                  out_valid_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = ST_IDLE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         xor_q       <= 1'b0;
         out_data_q  <= '0;
         pec_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         xor_q       <= xor_d;
         out_data_q  <= out_data_d;
         pec_q       <= pec_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign pec       = pec_q;

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (out_valid_d && pec_d && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic w_unused_cnt_w;
   assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
// ============================================================================
// Module  : tb_serial_parity_checker
// Brief   : Scoreboard bench for serial_parity_checker; one odd- and one
//           even-parity instance share stimulus. Honours PARITY_ERR_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_checker;

   localparam int DW = 4;
   localparam int CW = 2;

   typedef struct {
      logic [DW-1:0] data;
      logic          pec_o;
      logic          pec_e;
   } exp_t;

   logic          clk;
   logic          rst, in_valid, in_bit, frame_start;
   logic          busy_o, ov_o, pec_o;
   logic          busy_e, ov_e, pec_e;
   logic [DW-1:0] data_o, data_e;
`ifdef PARITY_ERR_CNT_EN
   logic [CW-1:0] ec_o, ec_e;
`endif

   serial_parity_checker #(.DATA_W(DW), .ODD(1'b1), .CNT_W(CW)) u_odd (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .frame_start(frame_start), .busy(busy_o), .out_valid(ov_o),
      .out_data(data_o), .pec(pec_o)
`ifdef PARITY_ERR_CNT_EN
      , .err_cnt(ec_o)
`endif
   );

   serial_parity_checker #(.DATA_W(DW), .ODD(1'b0), .CNT_W(CW)) u_even (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
      .frame_start(frame_start), .busy(busy_e), .out_valid(ov_e),
      .out_data(data_e), .pec(pec_e)
`ifdef PARITY_ERR_CNT_EN
      , .err_cnt(ec_e)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   bit            mon_en  = 1'b0;
   exp_t          sb[$];
   bit            frame_q[$];
   logic [DW-1:0] exp_data = '0;
   logic          exp_pec_o = 1'b0, exp_pec_e = 1'b0;
   int            exp_ec_o = 0, exp_ec_e = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: a frame is the list of bits since the last frame_start;
   // once it holds DW bits the next plain valid bit is the parity bit.
   task automatic step(input bit r, input bit v, input bit s, input bit b);
      rst = r; in_valid = v; frame_start = s; in_bit = b;
      @(posedge clk);
      if (r) begin
         frame_q.delete();
         exp_data = '0; exp_pec_o = 1'b0; exp_pec_e = 1'b0;
         exp_ec_o = 0;  exp_ec_e = 0;
      end else if (v) begin
         if (s) begin
            frame_q.delete();
            frame_q.push_back(b);
         end else if (frame_q.size() == DW) begin
            exp_t e;
            int   ones;
            e.data = '0;
            foreach (frame_q[i]) e.data = {e.data[DW-2:0], frame_q[i]};
            ones    = $countones(e.data) + int'(b);
            e.pec_o = (ones % 2) == 0;
            e.pec_e = (ones % 2) == 1;
            sb.push_back(e);
            exp_data = e.data; exp_pec_o = e.pec_o; exp_pec_e = e.pec_e;
            if (e.pec_o && exp_ec_o < (1 << CW) - 1) exp_ec_o++;
            if (e.pec_e && exp_ec_e < (1 << CW) - 1) exp_ec_e++;
            frame_q.delete();
         end else if (frame_q.size() > 0) begin
            frame_q.push_back(b);
         end
      end
      #1;
      chk("busy_odd",  {31'd0, busy_o}, {31'd0, frame_q.size() != 0});
      chk("busy_even", {31'd0, busy_e}, {31'd0, frame_q.size() != 0});
`ifdef PARITY_ERR_CNT_EN
      chk("err_cnt_odd",  {30'd0, ec_o}, exp_ec_o);
      chk("err_cnt_even", {30'd0, ec_e}, exp_ec_e);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input bit p, input int gap);
      for (int i = 0; i < DW; i++) begin
         step(1'b0, 1'b1, i == 0, d[DW-1-i]);
         idle(gap);
      end
      step(1'b0, 1'b1, 1'b0, p);
   endtask

   // Monitor: pops the scoreboard on each out_valid, otherwise checks hold.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ov_o || ov_e) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", {31'd0, ov_o | ov_e}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_valid_odd",  {31'd0, ov_o}, 32'd1);
               chk("out_valid_even", {31'd0, ov_e}, 32'd1);
               chk("out_data_odd",   {28'd0, data_o}, {28'd0, e.data});
               chk("out_data_even",  {28'd0, data_e}, {28'd0, e.data});
               chk("pec_odd",        {31'd0, pec_o}, {31'd0, e.pec_o});
               chk("pec_even",       {31'd0, pec_e}, {31'd0, e.pec_e});
            end
         end else begin
            chk("hold_data_odd", {28'd0, data_o}, {28'd0, exp_data});
            chk("hold_pec_odd",  {31'd0, pec_o},  {31'd0, exp_pec_o});
            chk("hold_pec_even", {31'd0, pec_e},  {31'd0, exp_pec_e});
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; frame_start = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("reset_out_valid", {31'd0, ov_o}, 32'd0);
      chk("reset_out_data",  {28'd0, data_o}, 32'd0);
      chk("reset_pec",       {31'd0, pec_o}, 32'd0);
      mon_en = 1'b1;

      // stray valid bits while idle are ignored
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(4'b1011, 1'b0, 0);
      idle(2);
      send_frame(4'b0000, 1'b0, 0);
      idle(2);
      send_frame(4'b1100, 1'b1, 3);
      idle(2);
      // abort: frame_start on the third bit restarts the frame
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(4'b0110, 1'b1, 0);
      idle(2);
      // abort during the parity slot
      step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < DW - 1; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(4'b1001, 1'b0, 0);
      // back-to-back frames, then reset in the middle of a third
      send_frame(4'b0101, 1'b1, 0);
      send_frame(4'b1110, 1'b0, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("rst_mid_data", {28'd0, data_o}, 32'd0);
      chk("rst_mid_pec",  {31'd0, pec_o},  32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      idle(3);
      // error frames drive the counter into saturation
      for (int i = 0; i < 5; i++) send_frame(4'b0000, 1'b0, 0);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit v, s, r;
         r = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 9) < 7);
         if (frame_q.size() == 0) s = ($urandom_range(0, 1) == 1);
         else                     s = ($urandom_range(0, 19) == 0);
         step(r, v, s, 1'($urandom));
      end
      idle(4);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
